hb_rw_arbiter: RTL
==================

// Module: hb_rw_arbiter
// PURPOSE
//  Dual-channel (read/write independent) round-robin arbiter for the high-speed bus controller.
//  Grants one master per channel; read and write may be owned by different masters, or the same one (full duplex).
//  Grant is held until the owner's transaction completes or is withdrawn; a hold watchdog breaks deadlock.
//  Sits between the masters' req lines and the bus controller's channel multiplexers.
// PARAMETERS
//  MASTER_NUM  1   number of bus masters (1..16); index 0 is the core
//  MAX_HOLD    64  max cycles one grant may be held without done before forced release (>=2)
// PORTS
//  clk          in   1           system clock
//  rst_sync     in   1           synchronous reset, active-high
//  core_stall_n in   1           0 = pipeline frozen: no re-arbitration, grants held, watchdog paused
//  read_req     in   MASTER_NUM  per-master read request (level)
//  write_req    in   MASTER_NUM  per-master write request (level)
//  read_done    in   1           read transaction of current read owner completes this cycle
//  write_done   in   1           write transaction of current write owner completes this cycle
//  read_grant   out  MASTER_NUM  registered one-hot (or zero) read grant
//  write_grant  out  MASTER_NUM  registered one-hot (or zero) write grant
//  read_busy    out  1           read channel owned (= |read_grant)
//  write_busy   out  1           write channel owned (= |write_grant)
//  timeout      out  2           1-cycle pulse per channel on watchdog release, [0]=read [1]=write
// BEHAVIOUR
//  - Reset: grants 0, busy 0, timeout 0, both ptrs 0, both FSMs IDLE, hold counters 0.
//  - Two identical channel instances; description below per channel.
//  - FSM IDLE: if core_stall_n && |req -> GRANT, grant[winner] set next cycle (1-cycle latency).
//  - Winner: first requesting index scanning ptr, ptr+1, ... MASTER_NUM-1, 0 (wrap); ptr <= winner+1 mod MASTER_NUM.
//  - FSM GRANT: release when done=1 or req[owner]=0 (cancel). Release cycle re-arbitrates in the same cycle:
//    if another req present, grant moves to new winner next cycle (no idle bubble); else -> IDLE, grant 0.
//  - Owner requesting again after done competes normally; ptr already advanced, so others win first.
//  - done while IDLE or while core_stall_n=0 is ignored; done and cancel same cycle = one release.
//  - core_stall_n=0: state, grants, ptr, hold counter frozen; req changes are not sampled.
//  - Watchdog: hold_cnt counts GRANT cycles with core_stall_n=1 and done=0; reset to 0 on every new grant.
//    hold_cnt==MAX_HOLD-1 without done -> grant dropped next cycle, FSM IDLE, ptr <= 0, timeout pulse.
//    Forced IDLE lasts exactly one cycle (no grant) before normal arbitration resumes.
//  - Grants never change except at release/timeout edges; at most one bit set per channel.
//  - Read and write channels never interact; same master may hold both simultaneously.
//  - Counter width $clog2(MAX_HOLD+1); ptr width $clog2(MASTER_NUM), MASTER_NUM=1 uses width 1, ptr stays 0.
//  - Reset mid-transaction: grants drop the cycle after rst_sync is sampled, no timeout pulse.
// CONFIGURATION
//  HB_ARB_CORE_PRIO_EN defined: at every arbitration point master 0 wins if requesting, regardless of ptr;
//    ptr still updated to winner+1; watchdog unchanged.
//  Not defined: pure round-robin as above; master 0 treated like all others.
// TESTING
//  1 MASTER_NUM=3, read_req=3'b111 constant, read_done pulse every 2nd cycle -> read_grant 001,010,100,001 rotating.
//  2 read_req=001 and write_req=001 together -> both grants 001 next cycle; read_busy=write_busy=1.
//  3 read_req=010 held, read_done never -> grant 010 for 64 cycles, then 0 for 1 cycle, timeout=01 pulse, ptr=0.
//  4 core_stall_n=0 while owner=001, read_done=1 and read_req=110 -> grant stays 001 until core_stall_n=1.
//  5 HB_ARB_CORE_PRIO_EN, ptr=1, read_req=111 at release -> grant 001 (undef: grant 010).
//  6 owner 100 drops read_req, no other req -> grant 0 next cycle, FSM IDLE; rst_sync mid-grant -> all outputs 0.

Source files
------------

// File: rtl/hb_rw_arbiter.sv
// Dual-channel (read/write) round-robin arbiter with per-channel hold watchdog.
// Optional build macro HB_ARB_CORE_PRIO_EN: master 0 wins every arbitration it requests.
module hb_rw_arbiter #(
  parameter int MASTER_NUM = 1,
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic                  core_stall_n,
  input  logic [MASTER_NUM-1:0] read_req,
  input  logic [MASTER_NUM-1:0] write_req,
  input  logic                  read_done,
  input  logic                  write_done,
  output logic [MASTER_NUM-1:0] read_grant,
  output logic [MASTER_NUM-1:0] write_grant,
  output logic                  read_busy,
  output logic                  write_busy,
  output logic [1:0]            timeout
);

  localparam int PTR_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [MASTER_NUM-1:0] req;
    logic                  done;
    state_t                state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      next_ptr;
    logic [CNT_W-1:0]      hold_cnt;
    logic [MASTER_NUM-1:0] grant_q;
    logic [MASTER_NUM-1:0] win_onehot;
    logic                  timeout_q;
    logic                  found;
    logic                  release_now;
    int                    idx;
    int                    win;

    assign req  = (ch == 0) ? read_req  : write_req;
    assign done = (ch == 0) ? read_done : write_done;

    // Winner search starts at ptr and wraps; the owner sits last in the scan
    // because ptr already points one past it.
    always_comb begin
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int i = 0; i < MASTER_NUM; i++) begin
        idx = int'(ptr) + i;
        if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
        if (!found && ((req & (MASTER_NUM'(1) << idx)) != '0)) begin
          found = 1'b1;
          win   = idx;
        end
      end
`ifdef HB_ARB_CORE_PRIO_EN
      if (req[0]) begin
        found = 1'b1;
        win   = 0;
      end
`endif
      win_onehot  = MASTER_NUM'(1) << win;
      next_ptr    = (win + 1 >= MASTER_NUM) ? '0 : PTR_W'(win + 1);
      release_now = done || ((req & grant_q) == '0);
    end

    // A release re-arbitrates in the same cycle so a waiting master takes
    // over without an idle bubble; the watchdog instead forces one IDLE cycle.
    always_ff @(posedge clk) begin
      if (rst_sync) begin
        state     <= IDLE;
        ptr       <= '0;
        hold_cnt  <= '0;
        grant_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        timeout_q <= 1'b0;
        if (core_stall_n) begin
          case (state)
            IDLE: begin
              if (found) begin
                state    <= GRANT;
                grant_q  <= win_onehot;
                ptr      <= next_ptr;
                hold_cnt <= '0;
              end
            end
            GRANT: begin
              if (release_now) begin
                hold_cnt <= '0;
                if (found) begin
                  grant_q <= win_onehot;
                  ptr     <= next_ptr;
                end else begin
                  state   <= IDLE;
                  grant_q <= '0;
                end
              end else if (hold_cnt == HOLD_LIMIT) begin
                state     <= IDLE;
                grant_q   <= '0;
                ptr       <= '0;
                hold_cnt  <= '0;
                timeout_q <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: begin
              state   <= IDLE;
              grant_q <= '0;
            end
          endcase
        end
      end
    end
  end

  assign read_grant  = g_ch[0].grant_q;
  assign write_grant = g_ch[1].grant_q;
  assign read_busy   = |g_ch[0].grant_q;
  assign write_busy  = |g_ch[1].grant_q;
  assign timeout     = {g_ch[1].timeout_q, g_ch[0].timeout_q};

endmodule
